// File: rtl/sargantana_icache_checker_pipe.sv
// sargantana_icache_checker_pipe
//
// Registered instruction-cache hit checker. It compares the MMU physical tag
// against every way's read tag and picks the lowest-index hit way. It selects
// a FETCH_WIDTH chunk of that way's line. The result is held in a one-entry
// valid/ready output register.
//
// Optional feature macro: ICACHE_CHECKER_PERF_EN (saturating hit/miss counters).
// When the macro is undefined, hit_cnt_o and miss_cnt_o read 0 and perf_clr_i
// is ignored.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    request handshake
//   cline_tag_i            tag from the physical address
//   way_valid_bits_i       per-way valid bits
//   read_tags_i            per-way tags read from the tag SRAM
//   data_rd_i              per-way lines read from the data SRAM
//   fetch_idx_i            chunk index within the line
//   flush_i                kills the pending response and blocks acceptance
//   rsp_valid_o/ready_i    response handshake
//   rsp_hit_o, rsp_hit_vec_o, rsp_way_o, rsp_data_o, rsp_multi_hit_o  payload
//   perf_clr_i             clears the perf counters
//   hit_cnt_o, miss_cnt_o  accepted hit/miss counts
module sargantana_icache_checker_pipe #(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned LINE_WIDTH   = 512,
  parameter int unsigned FETCH_WIDTH  = 128,
  parameter int unsigned CNT_WIDTH    = 32,
  localparam int unsigned N_CHUNK       = LINE_WIDTH / FETCH_WIDTH,
  localparam int unsigned OFFSET_WIDTH  = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1,
  localparam int unsigned WAY_IDX_WIDTH = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [TAG_WIDTH-1:0]                     cline_tag_i,
  input  logic [ICACHE_N_WAY-1:0]                  way_valid_bits_i,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDTH-1:0]   read_tags_i,
  input  logic [ICACHE_N_WAY-1:0][LINE_WIDTH-1:0]  data_rd_i,
  input  logic [OFFSET_WIDTH-1:0]                  fetch_idx_i,
  input  logic                                     flush_i,
  output logic                                     rsp_valid_o,
  input  logic                                     rsp_ready_i,
  output logic                                     rsp_hit_o,
  output logic [ICACHE_N_WAY-1:0]                  rsp_hit_vec_o,
  output logic [WAY_IDX_WIDTH-1:0]                 rsp_way_o,
  output logic [FETCH_WIDTH-1:0]                   rsp_data_o,
  output logic                                     rsp_multi_hit_o,
  input  logic                                     perf_clr_i,
  output logic [CNT_WIDTH-1:0]                     hit_cnt_o,
  output logic [CNT_WIDTH-1:0]                     miss_cnt_o
);

  logic [ICACHE_N_WAY-1:0]  hit_vec;
  logic [ICACHE_N_WAY-1:0]  hit_vec_m1;
  logic                     hit_any;
  logic                     multi_hit;
  logic [WAY_IDX_WIDTH-1:0] sel_way;
  logic [LINE_WIDTH-1:0]    sel_line;
  logic [OFFSET_WIDTH-1:0]  chunk_idx;
  logic [FETCH_WIDTH-1:0]   sel_data;
  logic                     accept;

  logic                     rsp_valid_q;
  logic                     rsp_hit_q;
  logic [ICACHE_N_WAY-1:0]  rsp_hit_vec_q;
  logic [WAY_IDX_WIDTH-1:0] rsp_way_q;
  logic [FETCH_WIDTH-1:0]   rsp_data_q;
  logic                     rsp_multi_hit_q;

  always_comb begin
    for (int i = 0; i < int'(ICACHE_N_WAY); i++) begin
      hit_vec[i] = (read_tags_i[i] == cline_tag_i) & way_valid_bits_i[i];
    end
  end

  assign hit_any = |hit_vec;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign hit_vec_m1 = hit_vec - ICACHE_N_WAY'(1);
  assign multi_hit  = |(hit_vec & hit_vec_m1);

  // Walk from the top way down so the lowest-index hit is the last assignment.
  always_comb begin
    sel_way  = '0;
    sel_line = '0;
    for (int i = int'(ICACHE_N_WAY) - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_way  = WAY_IDX_WIDTH'(i);
        sel_line = data_rd_i[i];
      end
    end
  end

  // A single-chunk line has no meaningful index.
  assign chunk_idx = (N_CHUNK > 1) ? fetch_idx_i : '0;

  always_comb begin
    sel_data = '0;
    if (hit_any) begin
      for (int c = 0; c < int'(N_CHUNK); c++) begin
        if (chunk_idx == OFFSET_WIDTH'(c)) begin
          sel_data = sel_line[c*FETCH_WIDTH +: FETCH_WIDTH];
        end
      end
    end
  end

  assign req_ready_o = !flush_i && (!rsp_valid_q || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_hit_vec_q   <= '0;
      rsp_way_q       <= '0;
      rsp_data_q      <= '0;
      rsp_multi_hit_q <= 1'b0;
    end else if (flush_i) begin
      rsp_valid_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q     <= 1'b1;
      rsp_hit_q       <= hit_any;
      rsp_hit_vec_q   <= hit_vec;
      rsp_way_q       <= sel_way;
      rsp_data_q      <= sel_data;
      rsp_multi_hit_q <= multi_hit;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_hit_vec_o   = rsp_hit_vec_q;
  assign rsp_way_o       = rsp_way_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_multi_hit_o = rsp_multi_hit_q;

`ifdef ICACHE_CHECKER_PERF_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q;
  logic [CNT_WIDTH-1:0] miss_cnt_q;

  // Counted at accept, so a later flush does not uncount a request.
  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit_any && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
      end
      if (!hit_any && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign hit_cnt_o       = '0;
  assign miss_cnt_o      = '0;
`endif

endmodule
